uart_receiver_controller: RTL and testbench

UART_RECEIVER_CONTROLLER -- requirements
Module: UART_receiver_controller

---
 rtl/uart_receiver_controller_pkg.sv | 24 ++
 rtl/uart_receiver_controller_timeout_counter.sv | 39 +++
 rtl/uart_receiver_controller.sv | 167 ++++++++++++++++
 tb/tb_uart_receiver_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_controller_pkg.sv
// Shared system-controller constants for the UART receiver controller:
// command opcodes, fixed ALU operand register addresses and FSM state encoding.
package uart_receiver_controller_pkg;

   // Command opcodes that may start a frame
   localparam logic [7:0] OPC_WRITE    = 8'hAA;
   localparam logic [7:0] OPC_READ     = 8'hBB;
   localparam logic [7:0] OPC_ALU_OPS  = 8'hCC;
   localparam logic [7:0] OPC_ALU_FUNC = 8'hDD;

   // Register-file locations of the two ALU operands
   localparam logic [3:0] ADDR_OPERAND_A = 4'h0;
   localparam logic [3:0] ADDR_OPERAND_B = 4'h1;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WR_ADDR  = 3'd1;
   localparam logic [2:0] ST_WR_DATA  = 3'd2;
   localparam logic [2:0] ST_RD_ADDR  = 3'd3;
   localparam logic [2:0] ST_ALU_OP_A = 3'd4;
   localparam logic [2:0] ST_ALU_OP_B = 3'd5;
   localparam logic [2:0] ST_ALU_FUNC = 3'd6;

endpackage

// File: rtl/uart_receiver_controller_timeout_counter.sv
// Inter-byte idle-gap counter for the UART receiver controller.
// Only instantiated when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_receiver_controller_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic count_en_i,
   output logic expired_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign expired_o = (count_q == CNT_W'(TIMEOUT_CYCLES));

   // Count idle cycles inside a frame; saturate at the limit, restart on any byte
   always_comb begin
      count_d = count_q;
      if (clear_i || !count_en_i) begin
         count_d = '0;
      end else if (!expired_o) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_receiver_controller.sv
// UART receiver controller: decodes command frames from the UART receiver
// into register-file write/read strobes and ALU start commands.
// Optional feature macro: UART_RX_CTRL_TIMEOUT_EN (abandon a frame after an
// idle gap of TIMEOUT_CYCLES); without it the FSM waits indefinitely mid-frame.
module uart_receiver_controller
   import uart_receiver_controller_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDRESS_WIDTH  = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    receiver_parallel_data,
   input  logic                     receiver_parallel_data_valid,
   input  logic                     UART_receiver_controller_enable,
   output logic [ADDRESS_WIDTH-1:0] address,
   output logic                     write_enable,
   output logic [DATA_WIDTH-1:0]    write_data,
   output logic                     read_enable,
   output logic [3:0]               ALU_function,
   output logic                     ALU_enable,
   output logic                     ALU_clock_gate_enable
);

   localparam logic [DATA_WIDTH-1:0]    OPC_WR_W  = DATA_WIDTH'(OPC_WRITE);
   localparam logic [DATA_WIDTH-1:0]    OPC_RD_W  = DATA_WIDTH'(OPC_READ);
   localparam logic [DATA_WIDTH-1:0]    OPC_OPS_W = DATA_WIDTH'(OPC_ALU_OPS);
   localparam logic [DATA_WIDTH-1:0]    OPC_FN_W  = DATA_WIDTH'(OPC_ALU_FUNC);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_A_W  = ADDRESS_WIDTH'(ADDR_OPERAND_A);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_B_W  = ADDRESS_WIDTH'(ADDR_OPERAND_B);

   logic [2:0]               state_q,   state_d;
   logic [ADDRESS_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0]    wdata_q,   wdata_d;
   logic [3:0]               func_q,    func_d;
   logic                     we_q,      we_d;
   logic                     re_q,      re_d;
   logic                     alu_en_q,  alu_en_d;
   logic                     cg_q,      cg_d;
   logic                     timeout_expired;

   wire                      rx_vld  = receiver_parallel_data_valid;
   wire [DATA_WIDTH-1:0]     rx_byte = receiver_parallel_data;

`ifdef UART_RX_CTRL_TIMEOUT_EN
   uart_receiver_controller_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_counter (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (rx_vld),
      .count_en_i (state_q != ST_IDLE),
      .expired_o  (timeout_expired)
   );
`else
   // No idle-gap supervision in this build; the parameter stays in the list
   // so both builds share one interface, and folds to a constant here.
   assign timeout_expired = (TIMEOUT_CYCLES < 0);
`endif

   // Frame decoder: every state change is qualified by a valid byte
   always_comb begin
      state_d   = state_q;
      address_d = address_q;
      wdata_d   = wdata_q;
      func_d    = func_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      alu_en_d  = 1'b0;
      cg_d      = cg_q;
      // Gate drops the cycle after the ALU start strobe; a new ALU opcode
      // accepted in that same cycle below re-arms it.
      if (alu_en_q) begin
         cg_d = 1'b0;
      end
      if (rx_vld) begin
         case (state_q)
            ST_IDLE: begin
               if (UART_receiver_controller_enable) begin
                  if (rx_byte == OPC_WR_W) begin
                     state_d = ST_WR_ADDR;
                  end else if (rx_byte == OPC_RD_W) begin
                     state_d = ST_RD_ADDR;
                  end else if (rx_byte == OPC_OPS_W) begin
                     state_d = ST_ALU_OP_A;
                     cg_d    = 1'b1;
                  end else if (rx_byte == OPC_FN_W) begin
                     state_d = ST_ALU_FUNC;
                     cg_d    = 1'b1;
                  end
               end
            end
            ST_WR_ADDR: begin
               address_d = rx_byte[ADDRESS_WIDTH-1:0];
               state_d   = ST_WR_DATA;
            end
            ST_WR_DATA: begin
               wdata_d = rx_byte;
               we_d    = 1'b1;
               state_d = ST_IDLE;
            end
            ST_RD_ADDR: begin
               address_d = rx_byte[ADDRESS_WIDTH-1:0];
               re_d      = 1'b1;
               state_d   = ST_IDLE;
            end
            ST_ALU_OP_A: begin
               address_d = ADDR_A_W;
               wdata_d   = rx_byte;
               we_d      = 1'b1;
               state_d   = ST_ALU_OP_B;
            end
            ST_ALU_OP_B: begin
               address_d = ADDR_B_W;
               wdata_d   = rx_byte;
               we_d      = 1'b1;
               state_d   = ST_ALU_FUNC;
            end
            ST_ALU_FUNC: begin
               func_d   = rx_byte[3:0];
               alu_en_d = 1'b1;
               state_d  = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (timeout_expired && (state_q != ST_IDLE)) begin
         // Abandon a stalled frame silently
         state_d = ST_IDLE;
         cg_d    = 1'b0;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         address_q <= '0;
         wdata_q   <= '0;
         func_q    <= '0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         alu_en_q  <= 1'b0;
         cg_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         address_q <= address_d;
         wdata_q   <= wdata_d;
         func_q    <= func_d;
         we_q      <= we_d;
         re_q      <= re_d;
         alu_en_q  <= alu_en_d;
         cg_q      <= cg_d;
      end
   end

   assign address               = address_q;
   assign write_enable          = we_q;
   assign write_data            = wdata_q;
   assign read_enable           = re_q;
   assign ALU_function          = func_q;
   assign ALU_enable            = alu_en_q;
   assign ALU_clock_gate_enable = cg_q;

endmodule

// File: tb/tb_uart_receiver_controller.sv
// Scoreboard bench for uart_receiver_controller: a frame-level reference model
// predicts each strobe; a negedge monitor pops and compares them.
module tb_uart_receiver_controller;

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int TO = 60;
`else
   localparam int TO = 1023;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       ctrl_en;
   logic [3:0] address;
   logic       write_enable;
   logic [7:0] write_data;
   logic       read_enable;
   logic [3:0] ALU_function;
   logic       ALU_enable;
   logic       ALU_clock_gate_enable;

   uart_receiver_controller #(
      .DATA_WIDTH     (8),
      .ADDRESS_WIDTH  (4),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                             (clk),
      .reset                           (rst_n),
      .receiver_parallel_data          (rx_data),
      .receiver_parallel_data_valid    (rx_valid),
      .UART_receiver_controller_enable (ctrl_en),
      .address                         (address),
      .write_enable                    (write_enable),
      .write_data                      (write_data),
      .read_enable                     (read_enable),
      .ALU_function                    (ALU_function),
      .ALU_enable                      (ALU_enable),
      .ALU_clock_gate_enable           (ALU_clock_gate_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 = register write, 1 = register read, 2 = ALU start
   typedef struct {
      int         kind;
      int         cyc;
      logic [3:0] addr;
      logic [7:0] data;
      logic [3:0] func;
      logic       cg;
   } ev_t;

   ev_t        expq[$];
   logic [7:0] frame[$];
   logic [3:0] exp_addr  = '0;
   logic [7:0] exp_wdata = '0;
   logic [3:0] exp_func  = '0;
   int         n_checks  = 0;
   int         n_pass    = 0;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic void push_ev(int kind, int t, logic [3:0] a, logic [7:0] d,
                                   logic [3:0] f, logic cg);
      ev_t e;
      e.kind = kind; e.cyc = t; e.addr = a; e.data = d; e.func = f; e.cg = cg;
      expq.push_back(e);
      if (kind == 0) begin exp_addr = a; exp_wdata = d; end
      if (kind == 1) exp_addr = a;
      if (kind == 2) exp_func = f;
   endfunction

   // Frame-level reference: a frame is an opcode plus a fixed number of bytes
   function automatic void model_byte(logic [7:0] b, logic en, int t);
      logic [7:0] b1;
      if (frame.size() == 0) begin
         if (en && (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD))
            frame.push_back(b);
         return;
      end
      frame.push_back(b);
      b1 = frame[1];
      case (frame[0])
         8'hAA: if (frame.size() == 3) begin push_ev(0, t, b1[3:0], b, 4'h0, 1'b0); frame.delete(); end
         8'hBB: begin push_ev(1, t, b1[3:0], 8'h00, 4'h0, 1'b0); frame.delete(); end
         8'hCC: begin
            if (frame.size() == 2) push_ev(0, t, 4'h0, b, 4'h0, 1'b1);
            else if (frame.size() == 3) push_ev(0, t, 4'h1, b, 4'h0, 1'b1);
            else begin push_ev(2, t, 4'h0, 8'h00, b[3:0], 1'b1); frame.delete(); end
         end
         default: begin push_ev(2, t, 4'h0, 8'h00, b[3:0], 1'b1); frame.delete(); end
      endcase
   endfunction

   // Monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && (write_enable || read_enable || ALU_enable)) begin
         ev_t e;
         int  kind;
         check("one_strobe", int'(write_enable) + int'(read_enable) + int'(ALU_enable), 1);
         kind = write_enable ? 0 : (read_enable ? 1 : 2);
         if (expq.size() == 0) begin
            check("unexpected_strobe_kind", kind, -1);
         end else begin
            e = expq.pop_front();
            check("strobe_kind", kind, e.kind);
            check("strobe_cycle", cyc, e.cyc);
            check("clock_gate_at_strobe", ALU_clock_gate_enable, e.cg);
            if (e.kind != 2) check("address", address, e.addr);
            if (e.kind == 0) check("write_data", write_data, e.data);
            if (e.kind == 2) check("ALU_function", ALU_function, e.func);
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic en);
      @(posedge clk); #2;
      rx_data = b; rx_valid = 1'b1; ctrl_en = en;
      model_byte(b, en, cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; rx_valid = 1'b0; ctrl_en = 1'b1; end
   endtask

   task automatic check_zero(string tag);
      check({tag, "_address"}, address, 0);
      check({tag, "_write_data"}, write_data, 0);
      check({tag, "_ALU_function"}, ALU_function, 0);
      check({tag, "_strobes"}, {write_enable, read_enable, ALU_enable}, 0);
      check({tag, "_clock_gate"}, ALU_clock_gate_enable, 0);
   endtask

   task automatic check_hold(string tag);
      check({tag, "_hold_address"}, address, exp_addr);
      check({tag, "_hold_write_data"}, write_data, exp_wdata);
      check({tag, "_hold_ALU_function"}, ALU_function, exp_func);
      check({tag, "_clock_gate_idle"}, ALU_clock_gate_enable, 0);
      check({tag, "_pending"}, expq.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      frame.delete();
      exp_addr = '0; exp_wdata = '0; exp_func = '0;
      check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ops[4];
      logic [7:0] b;
      ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;
      rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; ctrl_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("power_on");
      @(negedge clk);
      rst_n = 1'b1;

      // Write frame
      send(8'hAA, 1); send(8'h05, 1); send(8'h3C, 1); idle(6);
      check_hold("write");
      // Read frame
      send(8'hBB, 1); send(8'h02, 0); idle(6);
      check_hold("read");
      // Operands plus function
      send(8'hCC, 1); send(8'h12, 1); send(8'h34, 1); send(8'h01, 1); idle(6);
      check_hold("alu_ops");
      // Junk byte then function-only
      send(8'h55, 1); send(8'hDD, 1); send(8'h03, 1); idle(6);
      check_hold("alu_func");
      // Enable low in IDLE discards an opcode
      send(8'hAA, 0); send(8'h09, 1); send(8'h77, 1); idle(6);
      check_hold("enable_low");
      // Reset mid-frame, then a read
      send(8'hAA, 1); send(8'h05, 1); idle(1);
      do_reset();
      send(8'hBB, 1); send(8'h07, 1); idle(6);
      check_hold("after_reset");

`ifdef UART_RX_CTRL_TIMEOUT_EN
      send(8'hAA, 1); idle(TO + 10);
      frame.delete();
      send(8'h3C, 1); idle(6);
      check_hold("timeout");
`endif

      // Randomized traffic, back-to-back bytes included
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 4) b = ops[$urandom_range(0, 3)];
         else b = 8'($urandom_range(0, 255));
         send(b, ($urandom_range(0, 9) != 0));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(6);
      check("random_pending", expq.size(), 0);
      do_reset();
      idle(4);
      check_zero("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
